ysyx_22041461_ifu: RTL and testbench



---
 rtl/ysyx_22041461_ifu_if.sv | 38 +++
 rtl/ysyx_22041461_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_22041461_ifu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_ifu_if
// Bundles the fetch unit's two handshakes plus the redirect input.
//   Instruction memory: imem_req_valid/imem_req_ready/imem_req_addr carry a
//     request; imem_rsp_valid/imem_rsp_data return the word (no ready).
//   Decoder: inst_valid/inst_ready qualify inst, pc and snpc.
//   Redirect: redirect_valid/redirect_pc select the next PC on acceptance.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends combinationally on ready, and payload
// stays stable while valid is high and ready is low.
// Modports: master = fetch unit side, slave = memory/decoder side.
// ----------------------------------------------------------------------------
interface ysyx_22041461_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] snpc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22041461_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_ifu
// Instruction fetch unit. Owns the architectural PC, issues one fetch at a
// time to instruction memory and holds the fetched word for the decoder.
// On decoder acceptance the PC moves to snpc or to the redirect target.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         ysyx_22041461_ifu_if.master (memory, decoder, redirect)
//   dbg_state   current FSM state (IDLE=0, REQ=1, WAIT=2, HOLD=3, FAULT=4)
//   fetch_fault only with IFU_MISALIGN_CHECK_EN: high once a misaligned PC
//               was about to be fetched, held until reset
// Build option: define IFU_MISALIGN_CHECK_EN to add the misalignment trap.
// ----------------------------------------------------------------------------
module ysyx_22041461_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          INST_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22041461_ifu_if.master        bus,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic                       fetch_fault,
`endif
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        FAULT = 3'd4
`endif
    } state_t;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    state_t            state;
    state_t            state_next;
    logic [63:0]       pc_q;
    logic [63:0]       pc_next;
    logic [63:0]       snpc_w;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_next;

    // Wraps modulo 2^64 with no overflow indication.
    assign snpc_w = pc_q + 64'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            inst_q <= NOP;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            inst_q <= inst_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        inst_next  = inst_q;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    state_next = FAULT;
                end else if (bus.imem_req_ready) begin
                    state_next = WAIT;
                end
`else
                if (bus.imem_req_ready) begin
                    state_next = WAIT;
                end
`endif
            end
            // Responses outside WAIT (stale or spurious) never reach here.
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    inst_next  = bus.imem_rsp_data;
                    state_next = HOLD;
                end
            end
            // Redirect is only looked at on the accepting edge.
            HOLD: begin
                if (bus.inst_ready) begin
                    pc_next    = bus.redirect_valid ? bus.redirect_pc : snpc_w;
                    state_next = REQ;
                end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            FAULT: state_next = FAULT;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Valids come from registered state (and registered pc) only.
`ifdef IFU_MISALIGN_CHECK_EN
    assign bus.imem_req_valid = (state == REQ) && (pc_q[1:0] == 2'b00);
    assign fetch_fault        = (state == FAULT);
`else
    assign bus.imem_req_valid = (state == REQ);
`endif
    assign bus.inst_valid    = (state == HOLD);
    assign bus.imem_req_addr = pc_q;
    assign bus.pc            = pc_q;
    assign bus.snpc          = snpc_w;
    assign bus.inst          = inst_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041461_ifu
// Directed vector table, hand-written reset/fault sequences, then random
// traffic scored against a transaction-level fetch model.
// ----------------------------------------------------------------------------
module tb_ysyx_22041461_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
`ifdef IFU_MISALIGN_CHECK_EN
    logic       fetch_fault;
`endif

    ysyx_22041461_ifu_if bus_if ();

    ysyx_22041461_ifu dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
`ifdef IFU_MISALIGN_CHECK_EN
        .fetch_fault(fetch_fault),
`endif
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic xv, input logic [63:0] xpc);
        bus_if.imem_req_ready = rdy;
        bus_if.imem_rsp_valid = rv;
        bus_if.imem_rsp_data  = rd;
        bus_if.inst_ready     = ir;
        bus_if.redirect_valid = xv;
        bus_if.redirect_pc    = xpc;
    endtask

    // Reset for two edges; returns at the negedge where rst has just dropped.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        xv;
        logic [63:0] xpc;
        logic        e_rv;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic ir, logic xv,
                                logic [63:0] xpc, logic e_rv, logic e_iv,
                                logic [31:0] e_inst, logic [63:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xpc = xpc;
        v.e_rv = e_rv; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    // Checks applied to the outputs visible during one cycle.
    task automatic chk_out(input string tag, input logic e_rv, input logic e_iv,
                           input logic [31:0] e_inst, input logic [63:0] e_pc);
        chk({tag, ".req_valid"}, bus_if.imem_req_valid, e_rv);
        chk({tag, ".inst_valid"}, bus_if.inst_valid, e_iv);
        chk({tag, ".inst"}, bus_if.inst, e_inst);
        chk({tag, ".pc"}, bus_if.pc, e_pc);
        chk({tag, ".addr"}, bus_if.imem_req_addr, e_pc);
        chk({tag, ".snpc"}, bus_if.snpc, e_pc + 64'd4);
    endtask

    vec_t        tbl[25];
    logic [31:0] exp_q[$];
    logic [63:0] mpc;
    logic [63:0] rpc;
    bit          pending;
    bit          holding;
    int          retired;
    logic        r_rdy, r_rv, r_ir, r_xv;
    logic [31:0] r_rd;

    initial begin
        localparam logic [63:0] P0 = RST_PC;
        localparam logic [63:0] P1 = RST_PC + 64'd4;
        localparam logic [63:0] PR = 64'h0000_0000_8000_0100;
        localparam logic [63:0] PW = 64'hFFFF_FFFF_FFFF_FFFC;

        //            rdy rv rd            ir xv xpc                   erv eiv einst         epc
        tbl[0]  = mk(1, 0, 32'h0,          0, 0, 64'h0,                0, 0, 32'h0000_0013, P0);
        tbl[1]  = mk(1, 1, 32'hDEAD_BEEF,  0, 0, 64'h0,                1, 0, 32'h0000_0013, P0);
        tbl[2]  = mk(0, 1, 32'h0000_0413,  0, 1, 64'h8000_0200,        0, 0, 32'h0000_0013, P0);
        tbl[3]  = mk(0, 0, 32'h0,          0, 1, 64'h8000_0200,        0, 1, 32'h0000_0413, P0);
        for (int i = 4; i < 8; i++)
            tbl[i] = mk(1, 1, 32'hCAFE_F00D, 0, 0, 64'h0,              0, 1, 32'h0000_0413, P0);
        tbl[8]  = mk(0, 0, 32'h0,          1, 0, 64'h0,                0, 1, 32'h0000_0413, P0);
        tbl[9]  = mk(0, 1, 32'hBAD0_0001,  0, 0, 64'h0,                1, 0, 32'h0000_0413, P1);
        tbl[10] = mk(0, 0, 32'h0,          0, 1, 64'h8000_0300,        1, 0, 32'h0000_0413, P1);
        tbl[11] = mk(0, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h0000_0413, P1);
        tbl[12] = mk(0, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h0000_0413, P1);
        tbl[13] = mk(1, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h0000_0413, P1);
        tbl[14] = mk(0, 0, 32'h0,          1, 1, 64'h8000_0400,        0, 0, 32'h0000_0413, P1);
        tbl[15] = mk(0, 1, 32'h0010_0093,  0, 0, 64'h0,                0, 0, 32'h0000_0413, P1);
        tbl[16] = mk(0, 0, 32'h0,          1, 1, PR,                   0, 1, 32'h0010_0093, P1);
        tbl[17] = mk(1, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h0010_0093, PR);
        tbl[18] = mk(0, 1, 32'h0000_0073,  0, 0, 64'h0,                0, 0, 32'h0010_0093, PR);
        tbl[19] = mk(0, 0, 32'h0,          1, 1, PW,                   0, 1, 32'h0000_0073, PR);
        tbl[20] = mk(1, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h0000_0073, PW);
        tbl[21] = mk(0, 1, 32'h1111_1113,  0, 0, 64'h0,                0, 0, 32'h0000_0073, PW);
        tbl[22] = mk(0, 0, 32'h0,          1, 0, 64'h0,                0, 1, 32'h1111_1113, PW);
        tbl[23] = mk(1, 0, 32'h0,          0, 0, 64'h0,                1, 0, 32'h1111_1113, 64'h0);
        tbl[24] = mk(0, 0, 32'h0,          0, 0, 64'h0,                0, 0, 32'h1111_1113, 64'h0);

        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_iv, tbl[i].e_inst, tbl[i].e_pc);
`ifdef IFU_MISALIGN_CHECK_EN
            chk($sformatf("vec%0d.fault", i), fetch_fault, 1'b0);
`endif
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].xv, tbl[i].xpc);
        end

        // Reset while a fetch is outstanding, then a late response arrives.
        do_reset();
        drive(0, 1, 32'hBAD0_BAD0, 0, 0, 64'h0);
        chk_out("rst_idle", 0, 0, 32'h0000_0013, RST_PC);
        @(negedge clk);
        chk_out("rst_req", 1, 0, 32'h0000_0013, RST_PC);
        drive(1, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        drive(0, 1, 32'h0000_0413, 0, 0, 64'h0);
        @(negedge clk);
        chk_out("rst_hold", 0, 1, 32'h0000_0413, RST_PC);
        drive(0, 0, 32'h0, 1, 0, 64'h0);

        // Zero-wait memory: one instruction every third cycle.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_out($sformatf("seq%0d_req", i), 1, 0, 32'h0000_0413 + 32'(i - 1), RST_PC + 64'(4 * i));
            drive(1, 0, 32'h0, 0, 0, 64'h0);
            @(negedge clk);
            chk($sformatf("seq%0d_wait_rv", i), bus_if.imem_req_valid, 1'b0);
            chk($sformatf("seq%0d_wait_iv", i), bus_if.inst_valid, 1'b0);
            drive(0, 1, 32'h0000_0413 + 32'(i), 0, 0, 64'h0);
            @(negedge clk);
            chk_out($sformatf("seq%0d_hold", i), 0, 1, 32'h0000_0413 + 32'(i), RST_PC + 64'(4 * i));
            drive(0, 0, 32'h0, 1, (i == 3), 64'h0000_0000_8000_0102);
        end

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned target: no request, fault latched until reset.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, 1, 32'h0, 1, 0, 64'h0);
            chk($sformatf("mis%0d.req_valid", i), bus_if.imem_req_valid, 1'b0);
            chk($sformatf("mis%0d.inst_valid", i), bus_if.inst_valid, 1'b0);
            chk($sformatf("mis%0d.fault", i), fetch_fault, (i > 0));
        end
        do_reset();
        chk("mis_rst.fault", fetch_fault, 1'b0);
`else
        // Without the check a misaligned pc is fetched unchanged.
        @(negedge clk);
        chk_out("mis_req", 1, 0, 32'h0000_0416, 64'h0000_0000_8000_0102);
        drive(0, 0, 32'h0, 0, 0, 64'h0);
`endif

        // Random traffic against a fetch-transaction model.
        do_reset();
        chk("rnd_idle.req_valid", bus_if.imem_req_valid, 1'b0);
        chk("rnd_idle.inst_valid", bus_if.inst_valid, 1'b0);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0, 0, 64'h0);
        mpc = RST_PC; pending = 0; holding = 0; retired = 0;
        exp_q.delete();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            chk("rnd.req_valid", bus_if.imem_req_valid, !pending && !holding);
            chk("rnd.inst_valid", bus_if.inst_valid, holding);
            if (bus_if.imem_req_valid)
                chk("rnd.addr", bus_if.imem_req_addr, mpc);
            if (bus_if.inst_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd.exp_q_empty", 1'b1, 1'b0);
                end else begin
                    chk("rnd.inst", bus_if.inst, exp_q[0]);
                end
                chk("rnd.pc", bus_if.pc, mpc);
                chk("rnd.snpc", bus_if.snpc, mpc + 64'd4);
            end
            r_rdy = 1'($urandom_range(0, 1));
            r_rv  = ($urandom_range(0, 2) == 0);
            r_rd  = $urandom;
            r_ir  = 1'($urandom_range(0, 1));
            r_xv  = ($urandom_range(0, 3) == 0);
            rpc   = {$urandom, $urandom} & ~64'd3;
            drive(r_rdy, r_rv, r_rd, r_ir, r_xv, rpc);
            // Effect of the coming edge on the fetch transaction.
            if (holding && r_ir) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                mpc = r_xv ? rpc : mpc + 64'd4;
                holding = 0;
                retired++;
            end else if (pending && r_rv) begin
                exp_q.push_back(r_rd);
                pending = 0;
                holding = 1;
            end else if (!pending && !holding && r_rdy) begin
                pending = 1;
            end
        end
        chk("rnd.progress", (retired >= 50), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
